// File: rtl/tinyqv_uart_pkg.sv
// Shared UART definitions for the tinyQV debug UART receiver and transmitter:
// bit-period computation and receiver state encoding.
`timescale 1ns/1ps
package tinyqv_uart_pkg;

  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; both flops reset to 1 so an
// idle-high line looks idle straight out of reset.
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/debug_uart_rx.sv
// Debug UART receiver: 8N1, LSB first, single-byte buffer with sticky overrun
// and framing-error flags; rx_valid doubles as a level interrupt.
`timescale 1ns/1ps
module debug_uart_rx
  import tinyqv_uart_pkg::*;
#(
  parameter int CLK_HZ   = 64_000_000,
  parameter int BIT_RATE = 4_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int CNT_W = $clog2(CPB);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CPB - 1);

  logic             w_rxd_sync;
  logic             r_rxd_q;
  logic [2:0]       r_arm;
  logic             w_fall;
  logic             w_cnt_zero;

  uart_rx_state_t   r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             w_accept;
  logic             w_frame_err;

  logic [7:0]       r_rx_data;
  logic             r_rx_valid;
  logic             r_rx_overrun;
  logic             r_rx_frame_err;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (uart_rxd),
    .o_q   (w_rxd_sync)
  );

  // r_arm masks edge detection until the synchroniser and r_rxd_q hold real
  // line samples, so a line already low at reset release is not a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxd_q <= 1'b1;
      r_arm   <= 3'b000;
    end else begin
      r_rxd_q <= w_rxd_sync;
      r_arm   <= {r_arm[1:0], 1'b1};
    end
  end

  assign w_fall     = r_arm[2] & r_rxd_q & ~w_rxd_sync;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_accept      = 1'b0;
    w_frame_err   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_state_nxt = START;
          w_cnt_nxt   = HALF_LOAD;
        end
      end
      START: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (w_rxd_sync) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt   = DATA;
          w_cnt_nxt     = FULL_LOAD;
          w_bit_idx_nxt = 3'd0;
        end
      end
      DATA: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_shift_nxt = {w_rxd_sync, r_shift[7:1]};
          w_cnt_nxt   = FULL_LOAD;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (!w_cnt_zero) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (w_rxd_sync) begin
          w_accept    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_frame_err = 1'b1;
          w_state_nxt = BREAK;
        end
      end
      BREAK: begin
        if (w_rxd_sync) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
  end

  // A read clears the flags first; a same-cycle accept or framing error then
  // takes precedence, and a read in the accept cycle suppresses the overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data      <= 8'h00;
      r_rx_valid     <= 1'b0;
      r_rx_overrun   <= 1'b0;
      r_rx_frame_err <= 1'b0;
    end else begin
      if (rx_read) begin
        r_rx_valid     <= 1'b0;
        r_rx_overrun   <= 1'b0;
        r_rx_frame_err <= 1'b0;
      end
      if (w_accept) begin
        r_rx_data  <= r_shift;
        r_rx_valid <= 1'b1;
        if (r_rx_valid && !rx_read) begin
          r_rx_overrun <= 1'b1;
        end
      end
      if (w_frame_err) begin
        r_rx_frame_err <= 1'b1;
      end
    end
  end

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_overrun   = r_rx_overrun;
  assign rx_frame_err = r_rx_frame_err;
  assign rx_busy      = (r_state != IDLE);

endmodule
